// File: rtl/car_motion_pkg.sv
// car_motion_pkg: shared state type, widths and wheel decoding for the car motion controller.
package car_motion_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SPEED, S_HEAD, S_DONE} state_t;
   localparam int HEADING_MOD = 360;
   localparam int PEDAL_W     = 3;
   localparam int WHEEL_W     = 4;
   localparam int SPEED_W     = 8;
   localparam int HEADING_W   = 9;
   localparam int SHARP_LEVEL = 7;
   // Code -8 has no positive twin, so it is folded onto -7 to keep steering symmetric
   function automatic logic signed [10:0] wheel_value(input logic [WHEEL_W-1:0] w);
      return (w == 4'b1000) ? -11'sd7 : 11'(signed'(w));
   endfunction
endpackage

// File: rtl/motion_tick_gen.sv
// motion_tick_gen: free-running update tick counter with pause freeze and synchronous clear.
module motion_tick_gen #(
   parameter int TICK_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_pause,
   output logic o_tick
);
   localparam int CW = $clog2(TICK_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
   logic [CW-1:0] count;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) count <= '0;
      else count <= i_clear ? '0 : i_pause ? count : (count == LAST) ? '0 : count + 1'b1;
   assign o_tick = (count == LAST) && !i_pause;
endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: integrates pedal and wheel levels into a saturating speed and a wrapping heading,
// one multi-cycle update per tick, announced by a one-cycle strobe.
module car_motion_ctrl
   import car_motion_pkg::*;
#(
   parameter int TICK_CYCLES = 500000,
   parameter int MAX_SPEED   = 200,
   parameter int ACC_GAIN    = 2,
   parameter int DRAG        = 1,
   parameter int TURN_CAP    = 80,
   parameter int TURN_DECEL  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   input  logic                 i_pause,
   input  logic [PEDAL_W-1:0]   i_pedal_level,
   input  logic [WHEEL_W-1:0]   i_wheel_level,
   output logic [SPEED_W-1:0]   o_speed,
   output logic [HEADING_W-1:0] o_heading,
   output logic                 o_update,
   output logic                 o_busy
);
   localparam logic [9:0] MAX_S = 10'(MAX_SPEED);
   localparam logic [9:0] ACC_G = 10'(ACC_GAIN);
   localparam logic [9:0] DRAG_S = 10'(DRAG);
   localparam logic [9:0] CAP_S = 10'(TURN_CAP);
   localparam logic [9:0] DEC_S = 10'(TURN_DECEL);
   localparam logic signed [10:0] MOD = 11'(HEADING_MOD);
   localparam logic signed [10:0] SHARP = 11'(SHARP_LEVEL);
   state_t state, state_n;
   logic tick;
   logic [PEDAL_W-1:0] pedal, pedal_n;
   logic [WHEEL_W-1:0] wheel, wheel_n;
   logic [SPEED_W-1:0] speed_n;
   logic [HEADING_W-1:0] heading_n;
   logic signed [10:0] wv, h, h_wrap;
   logic [9:0] s10, acc, pedal_term, n;
   logic sharp;
   motion_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clear(i_clear),
      .i_pause(i_pause),
      .o_tick (tick)
   );
   assign wv = wheel_value(wheel);
   assign sharp = (wv == SHARP) || (wv == -SHARP);
   assign s10 = {2'b00, o_speed};
   assign acc = s10 + 10'(pedal) * ACC_G;
   assign pedal_term = (pedal != '0) ? ((acc > MAX_S) ? MAX_S : acc)
                                     : ((s10 >= DRAG_S) ? s10 - DRAG_S : 10'd0);
   // A sharp turn bleeds excess speed toward the cap instead of obeying the pedal
   assign n = !sharp ? pedal_term
            : (s10 > CAP_S) ? ((s10 >= CAP_S + DEC_S) ? s10 - DEC_S : CAP_S)
            : ((pedal_term > CAP_S) ? CAP_S : pedal_term);
   assign h = $signed({2'b00, o_heading}) + wv;
   assign h_wrap = (h < 0) ? h + MOD : (h >= MOD) ? h - MOD : h;
   always_comb begin
      state_n = state;
      pedal_n = pedal;
      wheel_n = wheel;
      speed_n = o_speed;
      heading_n = o_heading;
      if (i_clear) begin
         state_n = S_IDLE;
         speed_n = '0;
         heading_n = '0;
      end else begin
         case (state)
            S_IDLE: if (tick) begin
               state_n = S_SPEED;
               pedal_n = i_pedal_level;
               wheel_n = i_wheel_level;
            end
            S_SPEED: begin
               state_n = S_HEAD;
               speed_n = 8'(n);
            end
            S_HEAD: begin
               state_n = S_DONE;
               heading_n = (o_speed == '0) ? o_heading : 9'(h_wrap);
            end
            default: state_n = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state <= S_IDLE;
         pedal <= '0;
         wheel <= '0;
         o_speed <= '0;
         o_heading <= '0;
         o_update <= 1'b0;
         o_busy <= 1'b0;
      end else begin
         state <= state_n;
         pedal <= pedal_n;
         wheel <= wheel_n;
         o_speed <= speed_n;
         o_heading <= heading_n;
         o_update <= (state_n == S_DONE);
         o_busy <= (state_n != S_IDLE);
      end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl: random and directed stimulus against a cycle-level behavioural model of the motion rules.
module tb_car_motion_ctrl;
   localparam int T = 4;
   logic i_clk = 1'b0, i_rst = 1'b1, i_clear = 1'b0, i_pause = 1'b0;
   logic [2:0] i_pedal_level = '0;
   logic [3:0] i_wheel_level = '0;
   logic [7:0] o_speed;
   logic [8:0] o_heading;
   logic o_update, o_busy;
   int vectors = 0, miscompares = 0;
   int m_cnt = 0, m_phase = 0, m_lp = 0, m_lw = 0, m_spd = 0, m_hdg = 0, m_upd = 0;
   bit m_tick;

   car_motion_ctrl #(.TICK_CYCLES(T)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_pause(i_pause),
      .i_pedal_level(i_pedal_level), .i_wheel_level(i_wheel_level),
      .o_speed(o_speed), .o_heading(o_heading), .o_update(o_update), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   function automatic int wval(input logic [3:0] c);
      int w = c[3] ? int'(c) - 16 : int'(c);
      return (w == -8) ? -7 : w;
   endfunction

   function automatic int nspeed(input int s, input int p, input int w);
      int n = (p > 0) ? ((s + 2 * p > 200) ? 200 : s + 2 * p) : ((s > 0) ? s - 1 : 0);
      if (w == 7 || w == -7) n = (s > 80) ? ((s - 4 < 80) ? 80 : s - 4) : ((n > 80) ? 80 : n);
      return n;
   endfunction

   function automatic int nhead(input int hd, input int s, input int w);
      return (s == 0) ? hd : (hd + w + 360) % 360;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an update is a 3-cycle sequence after a tick (speed, then heading, then strobe)
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst || i_clear) begin
         m_cnt = 0; m_phase = 0; m_spd = 0; m_hdg = 0; m_upd = 0;
         if (i_rst) begin m_lp = 0; m_lw = 0; end
      end else begin
         m_tick = (m_cnt == T - 1) && !i_pause;
         if (!i_pause) m_cnt = (m_cnt + 1) % T;
         m_upd = 0;
         if (m_phase == 1) begin m_spd = nspeed(m_spd, m_lp, m_lw); m_phase = 2; end
         else if (m_phase == 2) begin m_hdg = nhead(m_hdg, m_spd, m_lw); m_upd = 1; m_phase = 3; end
         else if (m_phase == 3) m_phase = 0;
         else if (m_tick) begin m_lp = int'(i_pedal_level); m_lw = wval(i_wheel_level); m_phase = 1; end
      end
   end

   always @(negedge i_clk) begin
      chk("speed", int'(o_speed), m_spd);
      chk("heading", int'(o_heading), m_hdg);
      chk("update", int'(o_update), m_upd);
      chk("busy", int'(o_busy), int'(m_phase != 0));
   end

   task automatic wait_upd(input string tag, output int n);
      n = 0;
      do begin @(negedge i_clk); n++; end while (!o_update && n < 40);
      chk(tag, int'(o_update), 1);
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      do begin @(negedge i_clk); n++; end while (!o_busy && n < 40);
      chk(tag, int'(o_busy), 1);
   endtask

   task automatic tick_once(input int p, input int w);
      int n;
      i_pedal_level = 3'(p);
      i_wheel_level = 4'(w);
      wait_upd("update_timeout", n);
   endtask

   task automatic do_clear();
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
   endtask

   task automatic build(input int target);
      int cur = 0, st;
      do_clear();
      while (cur < target) begin
         st = (target - cur > 14) ? 14 : target - cur;
         tick_once(st / 2, 0);
         cur += st;
      end
   endtask

   task automatic sharp_case(input int from, input int exp);
      build(from);
      tick_once(7, 7);
      chk($sformatf("sharp_%0d", from), int'(o_speed), exp);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge i_clk);
      chk("reset_speed", int'(o_speed), 0);
      chk("reset_busy", int'(o_busy), 0);
      i_rst = 1'b0;
      tick_once(3, 0); chk("acc_6", int'(o_speed), 6);
      tick_once(3, 0); chk("acc_12", int'(o_speed), 12);
      tick_once(3, 0); chk("acc_18", int'(o_speed), 18);
      chk("acc_heading", int'(o_heading), 0);
      build(196);
      tick_once(7, 0); chk("sat_200", int'(o_speed), 200);
      tick_once(7, 0); chk("sat_hold", int'(o_speed), 200);
      build(2);
      tick_once(0, 0); chk("drag_1", int'(o_speed), 1);
      tick_once(0, 0); chk("drag_0", int'(o_speed), 0);
      tick_once(0, 0); chk("drag_floor", int'(o_speed), 0);
      build(14);
      tick_once(7, -3); chk("head_357", int'(o_heading), 357);
      tick_once(7, 5); chk("head_wrap_up", int'(o_heading), 2);
      build(2);
      tick_once(1, 3); chk("head_3", int'(o_heading), 3);
      tick_once(1, -5); chk("head_wrap_down", int'(o_heading), 358);
      build(2);
      tick_once(1, -8); chk("head_m8", int'(o_heading), 353);
      sharp_case(100, 96);
      sharp_case(82, 80);
      sharp_case(50, 64);
      sharp_case(76, 80);
      build(2);
      tick_once(0, 3);
      tick_once(0, 3); chk("still_speed", int'(o_speed), 0);
      chk("still_heading", int'(o_heading), 3);
      tick_once(0, 5); chk("still_heading2", int'(o_heading), 3);
      i_pedal_level = 3'd3;
      wait_busy("busy_timeout");
      @(negedge i_clk);
      do_clear();
      chk("clr_speed", int'(o_speed), 0);
      chk("clr_heading", int'(o_heading), 0);
      chk("clr_update", int'(o_update), 0);
      chk("clr_busy", int'(o_busy), 0);
      i_pedal_level = 3'd1;
      wait_upd("pre_pause", n);
      i_pause = 1'b1;
      repeat (10) begin
         @(negedge i_clk);
         chk("pause_busy", int'(o_busy), 0);
      end
      i_pause = 1'b0;
      wait_upd("post_pause", n);
      chk("pause_resume_latency", n, 4);
      i_pedal_level = 3'd2;
      wait_busy("busy_timeout2");
      #2 i_rst = 1'b1;
      #1;
      chk("arst_speed", int'(o_speed), 0);
      chk("arst_heading", int'(o_heading), 0);
      chk("arst_busy", int'(o_busy), 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      wait_upd("first_after_rst", n);
      chk("first_latency", n, 6);
      chk("first_speed", int'(o_speed), 4);
      repeat (400) begin
         @(negedge i_clk);
         i_pedal_level = 3'($urandom_range(0, 7));
         i_wheel_level = 4'($urandom);
         i_pause = ($urandom_range(0, 7) == 0);
         i_clear = ($urandom_range(0, 39) == 0);
      end
      @(negedge i_clk);
      i_pause = 1'b0;
      i_clear = 1'b0;
      repeat (8) @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
